// File: rtl/eight_bit_seq_divider.sv
// Sequential unsigned restoring divider.
// One shift-subtract-restore step per clock, WIDTH steps per division, with a
// start/done handshake. A zero divisor is answered in a single cycle with
// QUOTIENT all-ones, REMAINDER equal to the dividend and the div-zero flag set.
module eight_bit_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;

  logic [WIDTH:0]    partial;
  logic [WIDTH+1:0]  trial;
  logic              restore;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  // Because the partial remainder is always below the divisor, a successful
  // subtract fits in WIDTH bits, so any set bit above that marks a borrow.
  assign partial = {r_q, q_q[WIDTH-1]};
  assign trial   = {1'b0, partial} - {2'b00, divisor_q};
  assign restore = |trial[WIDTH+1:WIDTH];

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    r_d        = r_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i != '0) begin
            divisor_d  = divisor_i;
            q_d        = dividend_i;
            r_d        = '0;
            cnt_d      = CntW'(WIDTH);
            div_zero_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = RUN;
          end else begin
            q_d        = '1;
            r_d        = dividend_i;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end
        end
      end

      RUN: begin
        if (restore) begin
          r_d = partial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any division in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      q_q        <= '0;
      r_q        <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_eight_bit_seq_divider.sv
// Directed and seeded-random checks for the sequential restoring divider.
module tb_eight_bit_seq_divider;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       divZero;

  int passCount  = 0;
  int totalCount = 0;
  int cycleCount = 0;
  int tStart     = 0;

  eight_bit_seq_divider #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (divZero)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the START edge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present operands with START for exactly one rising edge, then scramble them.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    tStart   = cycleCount;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Wait (bounded) for DONE; report latency in edges after START and BUSY cycles.
  task automatic waitDone(output int latency, output int busyCycles);
    int guard;
    guard      = 0;
    busyCycles = 0;
    while (done !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) busyCycles++;
      @(posedge clk);
      #1;
      guard++;
    end
    latency = (done === 1'b1) ? (cycleCount - tStart) : -1;
  endtask

  task automatic runCase(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] expQ, input logic [7:0] expR, input logic checkClear);
    int lat;
    int busyCycles;
    int expLat;
    expLat = (b == 8'd0) ? 0 : 8;
    applyStimulus(a, b);
    waitDone(lat, busyCycles);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " busyCycles"}, busyCycles, expLat);
    checkOutput({tag, " busyAtDone"}, busy, 0);
    checkOutput({tag, " quotient"}, quotient, expQ);
    checkOutput({tag, " remainder"}, remainder, expR);
    checkOutput({tag, " divZero"}, divZero, (b == 8'd0) ? 1 : 0);
    if (checkClear) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " doneClears"}, done, 0);
      checkOutput({tag, " quotientHeld"}, quotient, expQ);
      checkOutput({tag, " remainderHeld"}, remainder, expR);
    end
  endtask

  initial begin
    int lat;
    int busyCycles;
    int doneSeen;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expQ;
    logic [7:0] expR;

    rstN     = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset divZero", divZero, 0);
    @(negedge clk);
    rstN = 1'b1;

    runCase("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b1);
    runCase("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b1);
    runCase("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b1);
    runCase("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b1);
    runCase("37/0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
    runCase("128/128", 8'd128, 8'd128, 8'd1, 8'd0, 1'b1);
    runCase("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b1);

    // A START while busy must not disturb the running division.
    applyStimulus(8'd200, 8'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start    = 1'b0;
    waitDone(lat, busyCycles);
    checkOutput("ignoreStart latency", lat, 8);
    checkOutput("ignoreStart quotient", quotient, 66);
    checkOutput("ignoreStart remainder", remainder, 2);
    @(posedge clk);
    #1;
    checkOutput("ignoreStart noSecondDone", done, 0);
    checkOutput("ignoreStart idle", busy, 0);

    // Reset in the middle of a division aborts it with no DONE.
    applyStimulus(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midReset busy", busy, 0);
    checkOutput("midReset done", done, 0);
    checkOutput("midReset quotient", quotient, 0);
    checkOutput("midReset remainder", remainder, 0);
    checkOutput("midReset divZero", divZero, 0);
    doneSeen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneSeen++;
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("midReset noDone", doneSeen, 0);
    checkOutput("midReset staysIdle", busy, 0);
    runCase("50/5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b1);

    // Back-to-back: new START issued during the DONE cycle.
    runCase("b2b 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    runCase("b2b 13/4", 8'd13, 8'd4, 8'd3, 8'd1, 1'b1);

    // Div-by-zero directly followed by a normal division in its DONE cycle.
    runCase("b2b 9/0", 8'd9, 8'd0, 8'hFF, 8'd9, 1'b0);
    runCase("b2b 9/4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b1);

    // Random operand pairs against a reference model and the invariant.
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        expQ = 8'hFF;
        expR = a;
      end else begin
        expQ = a / b;
        expR = a % b;
      end
      runCase($sformatf("rand%0d %0d/%0d", i, a, b), a, b, expQ, expR, (i % 2) == 0);
      if (b != 8'd0) begin
        checkOutput($sformatf("rand%0d invariant", i),
                    32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        checkOutput($sformatf("rand%0d remBelowDivisor", i),
                    (remainder < b) ? 32'd1 : 32'd0, 32'd1);
      end
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
